// File: rtl/bubble_page_receiver_if.sv
// rtl/bubble_page_receiver_if.sv - emulator serial pins and captured byte stream of the bubble page receiver
// crc_ok exists only when BUBBLE_RX_CRC_EN is defined.
interface bubble_page_receiver_if #(
   parameter int IDX_W = 8
);
   logic             CLKOUT;
   logic             nBSEN;
   logic             nREPEN;
   logic             DOUT0;
   logic             DOUT1;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic [IDX_W-1:0] byte_index;
   logic             page_done;
   logic             page_err;
   logic             busy;
`ifdef BUBBLE_RX_CRC_EN
   logic             crc_ok;
`endif

   modport master (
      output CLKOUT, nBSEN, nREPEN, DOUT0, DOUT1,
      input  byte_valid, byte_data, byte_index, page_done, page_err, busy
`ifdef BUBBLE_RX_CRC_EN
      , input crc_ok
`endif
   );

   modport slave (
      input  CLKOUT, nBSEN, nREPEN, DOUT0, DOUT1,
      output byte_valid, byte_data, byte_index, page_done, page_err, busy
`ifdef BUBBLE_RX_CRC_EN
      , output crc_ok
`endif
   );
endinterface

// File: rtl/bubble_page_receiver.sv
// rtl/bubble_page_receiver.sv - deserialises one bubble page from DOUT0/DOUT1 into a byte stream
// Optional page CRC-16/CCITT check enabled by BUBBLE_RX_CRC_EN.
module bubble_page_receiver #(
   parameter int PAGE_BYTES   = 64,
   parameter int SKIP_STROBES = 16,
   parameter int IDX_W        = 8
) (
   input  logic                  MCLK,
   input  logic                  MRST,
   bubble_page_receiver_if.slave bus
);
   localparam int SKW = $clog2(SKIP_STROBES + 2);
   localparam int CNW = IDX_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SKIP, S_CAPTURE, S_DONE} state_t;
   localparam state_t S_START = (SKIP_STROBES == 0) ? S_CAPTURE : S_SKIP;

   state_t           r_state, w_state_next;
   logic [1:0]       r_clk_sync, r_bsen_sync, r_rep_sync, r_d0_sync, r_d1_sync;
   logic             r_clk_prev, r_rep_prev;
   logic [SKW-1:0]   r_skip_cnt;
   logic [1:0]       r_bit_cnt;
   logic [CNW-1:0]   r_byte_cnt;
   logic [5:0]       r_shift;
   logic             r_byte_valid, r_page_done, r_page_err;
   logic [7:0]       r_byte_data;
   logic [IDX_W-1:0] r_byte_index;

   logic w_strobe, w_rep_fall, w_bsen_n, w_d0, w_d1, w_skip_last, w_page_full;
   logic w_busy, w_page_err, w_abort_rep, w_shift, w_skip_inc, w_new_page, w_enter_capture, w_page_end;
   logic [7:0] w_byte;

   assign w_bsen_n    = r_bsen_sync[1];
   assign w_d0        = r_d0_sync[1];
   assign w_d1        = r_d1_sync[1];
   assign w_strobe    = r_clk_sync[1] & ~r_clk_prev;
   assign w_rep_fall  = r_rep_prev & ~r_rep_sync[1];
   assign w_skip_last = (r_skip_cnt == SKW'(SKIP_STROBES - 1));
   assign w_page_full = (r_byte_cnt == CNW'(PAGE_BYTES));
   assign w_byte      = {w_d1, w_d0, r_shift};

   always_ff @(posedge MCLK) begin
      if (MRST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:    if (!w_bsen_n) w_state_next = S_ARMED;
         S_ARMED:   if (w_bsen_n) w_state_next = S_IDLE;
                    else if (w_rep_fall) w_state_next = S_START;
         S_SKIP:    if (w_bsen_n) w_state_next = S_IDLE;
                    else if (w_strobe && w_skip_last) w_state_next = S_CAPTURE;
         S_CAPTURE: if (w_bsen_n) w_state_next = S_IDLE;
                    else if (w_rep_fall) w_state_next = S_START;
                    else if (w_page_full) w_state_next = S_DONE;
         S_DONE:    w_state_next = w_bsen_n ? S_IDLE : S_ARMED;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // Aborts are decoded ahead of the strobe so a coincident strobe is dropped.
   always_comb begin
      w_busy          = (r_state == S_SKIP) || (r_state == S_CAPTURE);
      w_abort_rep     = (r_state == S_CAPTURE) && !w_bsen_n && w_rep_fall;
      w_page_err      = (w_busy && w_bsen_n) || w_abort_rep;
      w_shift         = (r_state == S_CAPTURE) && !w_bsen_n && !w_rep_fall && !w_page_full && w_strobe;
      w_skip_inc      = (r_state == S_SKIP) && !w_bsen_n && w_strobe;
      w_new_page      = ((r_state == S_ARMED) && !w_bsen_n && w_rep_fall) || w_abort_rep;
      w_enter_capture = (w_skip_inc && w_skip_last) || (w_new_page && (SKIP_STROBES == 0));
      w_page_end      = (r_state == S_CAPTURE) && !w_bsen_n && !w_rep_fall && w_page_full;
   end

`ifdef BUBBLE_RX_CRC_EN
   logic [15:0] r_crc, r_crc_rx;
   logic        r_crc_ok;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      end
      return r;
   endfunction
`endif

   always_ff @(posedge MCLK) begin
      if (MRST) begin
         r_clk_sync   <= 2'b00;
         r_bsen_sync  <= 2'b11;
         r_rep_sync   <= 2'b11;
         r_d0_sync    <= 2'b00;
         r_d1_sync    <= 2'b00;
         r_clk_prev   <= 1'b0;
         r_rep_prev   <= 1'b1;
         r_skip_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_byte_cnt   <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_page_done  <= 1'b0;
         r_page_err   <= 1'b0;
         r_byte_data  <= '0;
         r_byte_index <= '0;
`ifdef BUBBLE_RX_CRC_EN
         r_crc        <= 16'hFFFF;
         r_crc_rx     <= '0;
         r_crc_ok     <= 1'b0;
`endif
      end else begin
         r_clk_sync   <= {r_clk_sync[0], bus.CLKOUT};
         r_bsen_sync  <= {r_bsen_sync[0], bus.nBSEN};
         r_rep_sync   <= {r_rep_sync[0], bus.nREPEN};
         r_d0_sync    <= {r_d0_sync[0], bus.DOUT0};
         r_d1_sync    <= {r_d1_sync[0], bus.DOUT1};
         r_clk_prev   <= r_clk_sync[1];
         r_rep_prev   <= r_rep_sync[1];
         r_byte_valid <= 1'b0;
         r_page_done  <= 1'b0;
         r_page_err   <= w_page_err;

         if (w_new_page) begin
            r_skip_cnt <= '0;
         end else if (w_skip_inc) begin
            r_skip_cnt <= r_skip_cnt + 1'b1;
         end

         if (w_enter_capture) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
`ifdef BUBBLE_RX_CRC_EN
            r_crc      <= 16'hFFFF;
`endif
         end else if (w_shift) begin
            r_shift   <= w_byte[7:2];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 2'd3) begin
               r_byte_valid <= 1'b1;
               r_byte_data  <= w_byte;
               r_byte_index <= r_byte_cnt[IDX_W-1:0];
               r_byte_cnt   <= r_byte_cnt + 1'b1;
`ifdef BUBBLE_RX_CRC_EN
               // The final two bytes carry the stored CRC, high byte first.
               if (r_byte_cnt < CNW'(PAGE_BYTES - 2)) begin
                  r_crc <= crc16_byte(r_crc, w_byte);
               end else if (r_byte_cnt == CNW'(PAGE_BYTES - 2)) begin
                  r_crc_rx[15:8] <= w_byte;
               end else begin
                  r_crc_rx[7:0] <= w_byte;
               end
`endif
            end
         end

         if (w_page_end) begin
`ifdef BUBBLE_RX_CRC_EN
            r_crc_ok    <= (r_crc == r_crc_rx);
            r_page_done <= (r_crc == r_crc_rx);
            r_page_err  <= (r_crc != r_crc_rx);
`else
            r_page_done <= 1'b1;
`endif
         end
      end
   end

   assign bus.byte_valid = r_byte_valid;
   assign bus.byte_data  = r_byte_data;
   assign bus.byte_index = r_byte_index;
   assign bus.page_done  = r_page_done;
   assign bus.page_err   = r_page_err;
   assign bus.busy       = w_busy;
`ifdef BUBBLE_RX_CRC_EN
   assign bus.crc_ok     = r_crc_ok;
`endif
endmodule
